// File: rtl/cpu_mem_arbiter.sv
// N-port round-robin arbiter in front of one shared fixed-latency memory port.
// Define ARB_FIXED_PRIO_EN to make the lowest port index always win instead.
module cpu_mem_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 1,
    localparam int BE_W     = DATA_W / 8
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    input  logic [NUM_PORTS-1:0]      iReqRE,
    input  logic [NUM_PORTS-1:0]      iReqWE,
    input  logic [BE_W*NUM_PORTS-1:0] iReqBE,
    input  logic [ADDR_W*NUM_PORTS-1:0] iReqAddr,
    input  logic [DATA_W*NUM_PORTS-1:0] iReqWData,
    output logic [NUM_PORTS-1:0]      oAck,
    output logic [DATA_W-1:0]         oRData,
    output logic                      oBusy,
    output logic [1:0]                oState,
    output logic                      oMemRE,
    output logic                      oMemWE,
    output logic [BE_W-1:0]           oMemBE,
    output logic [ADDR_W-1:0]         oMemAddr,
    output logic [DATA_W-1:0]         oMemWData,
    input  logic [DATA_W-1:0]         iMemRData
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       gnt_q, gnt_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   re_q, re_d;
    logic                   we_q, we_d;
    logic [BE_W-1:0]        be_q, be_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [NUM_PORTS-1:0]   ack_q, ack_d;

    logic [NUM_PORTS-1:0]   req_vec;
    logic                   req_re_arr [NUM_PORTS];
    logic                   req_we_arr [NUM_PORTS];
    logic [BE_W-1:0]        req_be_arr [NUM_PORTS];
    logic [ADDR_W-1:0]      req_addr_arr [NUM_PORTS];
    logic [DATA_W-1:0]      req_wdata_arr [NUM_PORTS];

    logic [PTR_W-1:0]       win_idx;
    logic                   win_found;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign req_vec[gi]       = iReqRE[gi] | iReqWE[gi];
            assign req_re_arr[gi]    = iReqRE[gi];
            assign req_we_arr[gi]    = iReqWE[gi];
            assign req_be_arr[gi]    = iReqBE[gi*BE_W +: BE_W];
            assign req_addr_arr[gi]  = iReqAddr[gi*ADDR_W +: ADDR_W];
            assign req_wdata_arr[gi] = iReqWData[gi*DATA_W +: DATA_W];
        end
    endgenerate

`ifdef ARB_FIXED_PRIO_EN
    // Scan downwards so the lowest requesting index is the last one written.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(i);
            end
        end
    end
`else
    logic [PTR_W-1:0] ptr_q, ptr_d;

    // Search starts at the pointer and wraps; first requester found wins.
    always_comb begin
        int idx;
        idx       = 0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (int'(ptr_q) + i) % NUM_PORTS;
            if (!win_found && req_vec[idx]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(idx);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        re_d    = re_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = ack_q;
`ifndef ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_ACCESS;
                    gnt_d   = win_idx;
                    // A simultaneous read+write request is treated as a write.
                    re_d    = req_re_arr[win_idx] & ~req_we_arr[win_idx];
                    we_d    = req_we_arr[win_idx];
                    be_d    = req_be_arr[win_idx];
                    addr_d  = req_addr_arr[win_idx];
                    wdata_d = req_wdata_arr[win_idx];
                    cnt_d   = CNT_W'(MEM_LAT - 1);
`ifndef ARB_FIXED_PRIO_EN
                    ptr_d   = (win_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
`endif
                end
            end
            S_ACCESS: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_ACK;
                    ack_d   = NUM_PORTS'(1) << gnt_q;
                    if (re_q) begin
                        rdata_d = iMemRData;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                ack_d   = '0;
                rdata_d = '0;
                re_d    = 1'b0;
                we_d    = 1'b0;
                be_d    = '0;
                addr_d  = '0;
                wdata_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= '0;
`ifndef ARB_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            re_q    <= re_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
`ifndef ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Enables are only live in ACCESS; the payload is held through ACK.
    assign oMemRE    = (state_q == S_ACCESS) && re_q;
    assign oMemWE    = (state_q == S_ACCESS) && we_q;
    assign oMemBE    = be_q;
    assign oMemAddr  = addr_q;
    assign oMemWData = wdata_q;
    assign oRData    = rdata_q;
    assign oAck      = ack_q;
    assign oBusy     = (state_q != S_IDLE);
    assign oState    = state_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Randomized bench for cpu_mem_arbiter: reference arbiter + memory model, scoreboard monitor,
// then a directed mid-access reset check.
module tb_cpu_mem_arbiter;

    localparam int NP  = 3;
    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int LAT = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NP-1:0]     req_re_bus = '0;
    logic [NP-1:0]     req_we_bus = '0;
    logic [BW*NP-1:0]  req_be_bus = '0;
    logic [AW*NP-1:0]  req_addr_bus = '0;
    logic [DW*NP-1:0]  req_wdata_bus = '0;
    logic [NP-1:0]     ack;
    logic [DW-1:0]     rdata;
    logic              busy;
    logic [1:0]        state;
    logic              mem_re, mem_we;
    logic [BW-1:0]     mem_be;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata = '0;

    cpu_mem_arbiter #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)
    ) dut (
        .iCLK(clk), .iRST(rst_n),
        .iReqRE(req_re_bus), .iReqWE(req_we_bus), .iReqBE(req_be_bus),
        .iReqAddr(req_addr_bus), .iReqWData(req_wdata_bus),
        .oAck(ack), .oRData(rdata), .oBusy(busy), .oState(state),
        .oMemRE(mem_re), .oMemWE(mem_we), .oMemBE(mem_be),
        .oMemAddr(mem_addr), .oMemWData(mem_wdata), .iMemRData(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
        end
    endfunction

    function automatic logic [DW-1:0] bmask(logic [BW-1:0] be);
        logic [DW-1:0] m;
        m = '0;
        for (int b = 0; b < BW; b++) if (be[b]) m[b*8 +: 8] = 8'hFF;
        return m;
    endfunction

    typedef struct {
        int            port;
        logic [DW-1:0] rdata;
        int            ack_cyc;
        int            acc_cyc;
        logic          re;
        logic          we;
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
    } txn_t;

    txn_t ack_q[$];
    txn_t acc_q[$];

    // Per-master request state
    logic          p_re [NP];
    logic          p_we [NP];
    logic [BW-1:0] p_be [NP];
    logic [AW-1:0] p_addr [NP];
    logic [DW-1:0] p_wdata [NP];
    logic [NP-1:0] pending = '0;
    logic          active = 1'b0;
    logic          model_en = 1'b0;

    logic [DW-1:0] mem [8];
    logic [DW-1:0] ref_mem [8];

    task automatic pack();
        for (int p = 0; p < NP; p++) begin
            req_re_bus[p]                = p_re[p];
            req_we_bus[p]                = p_we[p];
            req_be_bus[p*BW +: BW]       = p_be[p];
            req_addr_bus[p*AW +: AW]     = p_addr[p];
            req_wdata_bus[p*DW +: DW]    = p_wdata[p];
        end
    endtask

    // Memory responder: data is presented only in the cycle it must be captured.
    int            m_rcnt = 0;
    logic [2:0]    m_ridx = '0;
    initial begin
        logic [DW-1:0] d;
        forever begin
            @(negedge clk);
            d = $urandom;
            if (m_rcnt > 0) begin
                m_rcnt--;
                if (m_rcnt == 0) d = mem[m_ridx];
            end
            mem_rdata = d;
            if (mem_re) begin
                m_rcnt = LAT;
                m_ridx = mem_addr[4:2];
            end
            if (mem_we) begin
                mem[mem_addr[4:2]] = (mem[mem_addr[4:2]] & ~bmask(mem_be)) | (mem_wdata & bmask(mem_be));
            end
        end
    end

    // Stimulus and reference arbiter
    int a_t, a_d, a_exp_st, a_w, a_idx, a_ptr = 0, a_next_free = 0, a_last_g = -100;
    initial begin
        logic [NP-1:0] reqv;
        int kind;
        txn_t e;
        forever begin
            @(negedge clk);
            if (model_en) begin
                a_t = cyc;
                a_d = a_t - a_last_g;
                if (a_d == 1) a_exp_st = 1;
                else if (a_d >= 2 && a_d <= LAT + 1) a_exp_st = 2;
                else if (a_d == LAT + 2) a_exp_st = 3;
                else a_exp_st = 0;
                chk("state", state, a_exp_st);
                chk("busy", busy, a_exp_st != 0);
                if (a_exp_st == 0) chk("idle_addr", mem_addr, 0);

                for (int p = 0; p < NP; p++) begin
                    if (pending[p] && ack[p]) begin
                        pending[p] = 1'b0;
                        p_re[p] = 1'b0;
                        p_we[p] = 1'b0;
                    end
                    if (!pending[p] && active) begin
                        p_addr[p]  = AW'($urandom);
                        p_wdata[p] = $urandom;
                        if ($urandom_range(0, 2) == 0) begin
                            kind       = $urandom_range(0, 3);
                            p_re[p]    = (kind != 1);
                            p_we[p]    = (kind == 1 || kind == 2);
                            p_addr[p]  = AW'($urandom_range(0, 7) * 4);
                            p_be[p]    = BW'($urandom_range(1, 15));
                            pending[p] = 1'b1;
                        end
                    end
                end
                pack();

                for (int p = 0; p < NP; p++) reqv[p] = p_re[p] | p_we[p];
                if (a_t >= a_next_free && reqv != '0) begin
                    a_w = -1;
`ifdef ARB_FIXED_PRIO_EN
                    for (int i = NP - 1; i >= 0; i--) if (reqv[i]) a_w = i;
`else
                    for (int i = 0; i < NP; i++) begin
                        a_idx = (a_ptr + i) % NP;
                        if (a_w < 0 && reqv[a_idx]) a_w = a_idx;
                    end
                    a_ptr = (a_w + 1) % NP;
`endif
                    e.port    = a_w;
                    e.acc_cyc = a_t + 1;
                    e.ack_cyc = a_t + LAT + 2;
                    e.re      = p_re[a_w] & ~p_we[a_w];
                    e.we      = p_we[a_w];
                    e.addr    = p_addr[a_w];
                    e.be      = p_be[a_w];
                    e.wdata   = p_wdata[a_w];
                    e.rdata   = e.we ? '0 : ref_mem[e.addr[4:2]];
                    if (e.we)
                        ref_mem[e.addr[4:2]] = (ref_mem[e.addr[4:2]] & ~bmask(e.be)) | (e.wdata & bmask(e.be));
                    ack_q.push_back(e);
                    acc_q.push_back(e);
                    a_last_g    = a_t;
                    a_next_free = a_t + LAT + 3;
                end
            end
        end
    end

    // Scoreboard monitor
    initial begin
        txn_t e;
        logic [NP-1:0] ev;
        forever begin
            @(negedge clk);
            if (model_en) begin
                if (mem_re || mem_we) begin
                    if (acc_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_mem_access: re=%0b we=%0b addr 0x%0h required none at cycle %0d",
                                 mem_re, mem_we, mem_addr, cyc);
                    end else begin
                        e = acc_q.pop_front();
                        chk("acc_cycle", cyc, e.acc_cyc);
                        chk("acc_re", mem_re, e.re);
                        chk("acc_we", mem_we, e.we);
                        chk("acc_addr", mem_addr, e.addr);
                        chk("acc_be", mem_be, e.be);
                        chk("acc_wdata", mem_wdata, e.wdata);
                    end
                end
                if (ack != '0) begin
                    if (ack_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_ack: got %b required none at cycle %0d", ack, cyc);
                    end else begin
                        e = ack_q.pop_front();
                        ev = '0;
                        ev[e.port] = 1'b1;
                        chk("ack_vec", ack, ev);
                        chk("ack_cycle", cyc, e.ack_cyc);
                        chk("ack_rdata", rdata, e.rdata);
                        $display("[TB] ack port %0d %s addr 0x%0h rdata 0x%0h cycle %0d",
                                 e.port, e.we ? "WR" : "RD", e.addr, rdata, cyc);
                    end
                end
            end
        end
    end

    initial begin
        int w;
        logic seen;
        for (int i = 0; i < 8; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        for (int p = 0; p < NP; p++) begin
            p_re[p] = 1'b0; p_we[p] = 1'b0; p_be[p] = '0; p_addr[p] = '0; p_wdata[p] = '0;
        end
        pack();

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", state, 0);
        rst_n = 1'b1;

        @(posedge clk); #1;
        model_en = 1'b1;
        active   = 1'b1;
        repeat (3000) @(posedge clk);
        #1 active = 1'b0;

        w = 0;
        while ((pending != '0 || ack_q.size() != 0 || acc_q.size() != 0) && w < 400) begin
            @(posedge clk);
            w++;
        end
        tests++;
        if (w >= 400) begin
            fails++;
            $display("FAIL drain_timeout: %0d acks still outstanding, required 0", ack_q.size());
        end
        repeat (2) @(posedge clk);
        #1 model_en = 1'b0;

        // Reset in the middle of a read aborts it.
        @(negedge clk);
        p_re[0] = 1'b1; p_addr[0] = 16'h0010; pack();
        w = 0;
        while (state != 2'd2 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("reach_wait", state, 2);
        rst_n = 1'b0;
        p_re[0] = 1'b0; pack();
        @(negedge clk);
        chk("abort_mem_re", mem_re, 0);
        chk("abort_mem_we", mem_we, 0);
        chk("abort_state", state, 0);
        chk("abort_busy", busy, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_ack", ack, 0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ack != '0) seen = 1'b1;
        end
        chk("no_ack_after_abort", seen, 0);

        // Pointer back at 0: port 0 wins a tie with port 1, then port 1 is served.
        p_re[0] = 1'b1; p_addr[0] = 16'h0004;
        p_re[1] = 1'b1; p_addr[1] = 16'h0008;
        pack();
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (ack == '0 && w < 20);
        chk("post_reset_first_ack", ack, 3'b001);
        $display("[TB] ack %b after reset, cycle %0d", ack, cyc);
        p_re[0] = 1'b0; pack();
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (ack == '0 && w < 20);
        chk("post_reset_second_ack", ack, 3'b010);
        $display("[TB] ack %b after reset, cycle %0d", ack, cyc);
        p_re[1] = 1'b0; pack();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
